// File: rtl/systemx_sweep_ctrl.sv
// Sequencer that sweeps SystemX inputs {A,B,C} through 0..7, compares F_0/F_1 per vector
// and reports results. Optional macro SYSTEMX_SWEEP_STOP_EN ends the sweep at the first mismatch.
module systemx_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       F_0,
  input  logic       F_1,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic [2:0] first_bad,
  output logic       first_bad_vld,
  output logic [7:0] tt_0
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_L = 8'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [2:0] fb_q, fb_d;
  logic       fbv_q, fbv_d;
  logic [7:0] tt_q, tt_d;
  logic       pass_q, pass_d;
  logic       bad;
  logic       last;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    fb_d    = fb_q;
    fbv_d   = fbv_q;
    tt_d    = tt_q;
    pass_d  = pass_q;
    bad     = F_0 ^ F_1;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          mcnt_d  = 4'd0;
          fb_d    = 3'd0;
          fbv_d   = 1'b0;
          tt_d    = 8'd0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == SETTLE_L) begin
          // Sample edge: F_0/F_1 have been stable for SETTLE_CYCLES+1 cycles.
          tt_d[vec_q] = F_0;
          cnt_d       = 8'd0;
          if (bad) begin
            mcnt_d = mcnt_q + 4'd1;
            if (!fbv_q) begin
              fb_d  = vec_q;
              fbv_d = 1'b1;
            end
          end
`ifdef SYSTEMX_SWEEP_STOP_EN
          last = (vec_q == 3'd7) || bad;
`else
          last = (vec_q == 3'd7);
`endif
          if (last) begin
            state_d = FINISH;
            pass_d  = (mcnt_d == 4'd0);
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      mcnt_q  <= 4'd0;
      fb_q    <= 3'd0;
      fbv_q   <= 1'b0;
      tt_q    <= 8'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      fb_q    <= fb_d;
      fbv_q   <= fbv_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
    end
  end

  // A/B/C come straight from the vector register, so they hold the last vector in IDLE.
  assign {A, B, C}     = vec_q;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == FINISH);
  assign pass          = pass_q;
  assign mismatch_cnt  = mcnt_q;
  assign first_bad     = fb_q;
  assign first_bad_vld = fbv_q;
  assign tt_0          = tt_q;

endmodule

// File: tb/tb_systemx_sweep_ctrl.sv
// Bench for systemx_sweep_ctrl: three instances (SETTLE_CYCLES 0, 2, 5) swept with directed
// and random truth tables against a cycle-count model derived from the sweep rules.
module tb_systemx_sweep_ctrl;

  localparam int NI = 3;
`ifdef SYSTEMX_SWEEP_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tbl0 = 8'd0;
  logic [7:0] tbl1 = 8'd0;

  logic       a [NI];
  logic       b [NI];
  logic       c [NI];
  logic       f0 [NI];
  logic       f1 [NI];
  logic       busy [NI];
  logic       done [NI];
  logic       pass [NI];
  logic       fbv [NI];
  logic [3:0] mcnt [NI];
  logic [2:0] fb [NI];
  logic [7:0] tt [NI];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 5;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : (g == 1) ? 2 : 5;
    assign f0[g] = tbl0[{a[g], b[g], c[g]}];
    assign f1[g] = tbl1[{a[g], b[g], c[g]}];
    systemx_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .F_0          (f0[g]),
      .F_1          (f1[g]),
      .A            (a[g]),
      .B            (b[g]),
      .C            (c[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .pass         (pass[g]),
      .mismatch_cnt (mcnt[g]),
      .first_bad    (fb[g]),
      .first_bad_vld(fbv[g]),
      .tt_0         (tt[g])
    );
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_results(input int i, input int n, input int e_mc, input int e_fb,
                             input int e_fbv, input int e_tt, input int e_pass);
    int s;
    s = settle_of(i);
    chk_val($sformatf("mcnt[S%0d,n%0d]", s, n), int'(mcnt[i]), e_mc);
    chk_val($sformatf("first_bad[S%0d,n%0d]", s, n), int'(fb[i]), e_fb);
    chk_val($sformatf("fbv[S%0d,n%0d]", s, n), int'(fbv[i]), e_fbv);
    chk_val($sformatf("tt_0[S%0d,n%0d]", s, n), int'(tt[i]), e_tt);
    chk_val($sformatf("pass[S%0d,n%0d]", s, n), int'(pass[i]), e_pass);
  endtask

  task automatic chk_reset_state(input int n);
    for (int i = 0; i < NI; i++) begin
      chk_val($sformatf("rst_abc[S%0d,n%0d]", settle_of(i), n), int'({a[i], b[i], c[i]}), 0);
      chk_val($sformatf("rst_busy[S%0d,n%0d]", settle_of(i), n), int'(busy[i]), 0);
      chk_val($sformatf("rst_done[S%0d,n%0d]", settle_of(i), n), int'(done[i]), 0);
      chk_results(i, n, 0, 0, 0, 0, 0);
    end
  endtask

  // One sweep on all instances. n counts cycles after the start edge (n=1 is the first RUN cycle).
  task automatic sweep(input logic [7:0] t0, input logic [7:0] t1, input bit noise, input int rst_at);
    logic [7:0] diff;
    int nbad, lowbad, last_v, e_mc, e_tt, min_done;
    int done_n [NI];
    tbl0 = t0;
    tbl1 = t1;
    diff = t0 ^ t1;
    nbad = 0;
    lowbad = -1;
    for (int v = 0; v < 8; v++) begin
      if (diff[v]) begin
        nbad++;
        if (lowbad < 0) lowbad = v;
      end
    end
    last_v = (STOP && lowbad >= 0) ? lowbad : 7;
    e_mc   = STOP ? ((lowbad >= 0) ? 1 : 0) : nbad;
    e_tt   = int'(t0) & ((1 << (last_v + 1)) - 1);
    min_done = 1000;
    for (int i = 0; i < NI; i++) begin
      done_n[i] = (last_v + 1) * (settle_of(i) + 1) + 1;
      if (done_n[i] < min_done) min_done = done_n[i];
    end
    start = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == rst_at + 1 && rst_at > 0) rst = 1'b0;
      if (rst_at > 0 && n > rst_at) begin
        chk_reset_state(n);
      end else begin
        for (int i = 0; i < NI; i++) begin
          int p, s;
          s = settle_of(i);
          p = s + 1;
          if (n < done_n[i]) begin
            chk_val($sformatf("busy[S%0d,n%0d]", s, n), int'(busy[i]), 1);
            chk_val($sformatf("done[S%0d,n%0d]", s, n), int'(done[i]), 0);
            chk_val($sformatf("abc[S%0d,n%0d]", s, n), int'({a[i], b[i], c[i]}), (n - 1) / p);
            if (n == 1) chk_results(i, n, 0, 0, 0, 0, 0);
          end else begin
            chk_val($sformatf("busy[S%0d,n%0d]", s, n), int'(busy[i]), 0);
            chk_val($sformatf("done[S%0d,n%0d]", s, n), int'(done[i]), int'(n == done_n[i]));
            chk_val($sformatf("abc[S%0d,n%0d]", s, n), int'({a[i], b[i], c[i]}), last_v);
            chk_results(i, n, e_mc, (lowbad >= 0) ? lowbad : 0, int'(lowbad >= 0), e_tt,
                        int'(e_mc == 0));
          end
        end
      end
      if (n == rst_at) rst = 1'b1;
      if (noise && n <= min_done && (rst_at == 0 || n < rst_at))
        start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state(0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state(0);

    sweep(8'hEA, 8'hEA, 1'b0, 0);
    sweep(8'hEA, 8'hEA ^ 8'h48, 1'b0, 0);
    sweep(8'hEA, 8'h00, 1'b1, 0);
    sweep(8'hEA, 8'hEA, 1'b0, 14);
    sweep(8'hEA, 8'hEA ^ 8'h48, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      r0 = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       r1 = r0;
        1:       r1 = r0 ^ (8'd1 << $urandom_range(0, 7));
        default: r1 = 8'($urandom);
      endcase
      sweep(r0, r1, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
